// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction fetch stage: the fetch FSM state
//   encoding, the ROM geometry, the halt sentinel and a small PC range helper.
// -----------------------------------------------------------------------------
package fetch_pkg;

    // Width of an instruction word and of the word-addressed PC.
    localparam int WORD_W = 32;

    // Number of instruction words held by the ROM.
    localparam int IMEM_DEPTH = 32;

    // Sentinel word that stops the fetch stage; it is never handed to decode.
    localparam logic [WORD_W-1:0] HALT_INSN = 32'hFFFF_FFFF;

    typedef logic [WORD_W-1:0] word_t;

    // Fetch stage control states.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } fetch_state_e;

    // True when the word-addressed PC points inside the ROM.
    function automatic logic pc_in_range(input word_t pc, input word_t depth);
        return (pc < depth);
    endfunction

endpackage : fetch_pkg

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   PC register and fetch stage in front of a combinational instruction ROM.
//   The PC is presented on imem_addr; the ROM answers in the same cycle and the
//   word is captured into a registered {out_insn, out_pc} slot that decode
//   drains through a valid/ready handshake. Redirects reload the PC, the halt
//   sentinel parks the stage in HALTED and a PC beyond the ROM parks it in
//   FAULT. Every output except imem_addr (which is the PC register itself) is
//   a flop.
//
// Ports
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   imem_addr       out  ROM word index (= PC register)
//   imem_rdata      in   ROM read data for imem_addr, same cycle
//   redirect_valid  in   load redirect_target into the PC
//   redirect_target in   new word-addressed PC
//   out_valid       out  out_insn/out_pc hold an instruction for decode
//   out_ready       in   decode accepts when out_valid && out_ready
//   out_insn        out  fetched instruction
//   out_pc          out  word address of out_insn
//   halted          out  stage stopped on the halt sentinel
//   fault           out  stage stopped on an out-of-range PC
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int          DEPTH     = fetch_pkg::IMEM_DEPTH,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_INSN = fetch_pkg::HALT_INSN
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault
);

    import fetch_pkg::*;

    localparam word_t DEPTH_W = word_t'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    logic         out_valid_q, out_valid_d;
    word_t        out_insn_q, out_insn_d;
    word_t        out_pc_q, out_pc_d;
    logic         halted_q, halted_d;
    logic         fault_q, fault_d;

    // -------------------------------------------------------------------------
    // Decoded conditions
    // -------------------------------------------------------------------------
    logic in_range_s;    // PC addresses a real ROM word
    logic xfer_s;        // decode takes the slot at the coming edge
    logic slot_free_s;   // slot may be overwritten at the coming edge
    logic halt_seen_s;   // ROM currently returns the sentinel

    // Handshake and fetch qualifiers derived from current state and inputs.
    always_comb begin
        in_range_s  = pc_in_range(pc_q, DEPTH_W);
        xfer_s      = out_valid_q & out_ready;
        slot_free_s = (~out_valid_q) | xfer_s;
        halt_seen_s = (imem_rdata == HALT_INSN);
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // Control state flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // A redirect always returns to FETCH. The range test precedes the halt
    // test so a sentinel read from beyond the ROM is still reported as a fault.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!in_range_s) begin
                        state_d = FAULT;
                    end else if (slot_free_s && halt_seen_s) begin
                        state_d = HALTED;
                    end else begin
                        state_d = FETCH;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath next values
    // -------------------------------------------------------------------------
    // The default for out_valid is "drain": a held word stays valid until
    // decode takes it. That single default covers stalls, the HALTED and
    // FAULT states, and the slot consumed while the sentinel is detected.
    always_comb begin
        pc_d        = pc_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_insn_d  = out_insn_q;
        out_pc_d    = out_pc_q;
        halted_d    = halted_q;
        fault_d     = fault_q;
        if (redirect_valid) begin
            // Any word still in the slot is either taken this edge or dropped.
            pc_d        = redirect_target;
            out_valid_d = 1'b0;
            halted_d    = 1'b0;
            fault_d     = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!in_range_s) begin
                        fault_d = 1'b1;
                    end else if (slot_free_s) begin
                        if (halt_seen_s) begin
                            // PC parks on the sentinel; nothing is captured.
                            halted_d = 1'b1;
                        end else begin
                            out_insn_d  = imem_rdata;
                            out_pc_d    = pc_q;
                            out_valid_d = 1'b1;
                            pc_d        = pc_q + 32'd1;
                        end
                    end else begin
                        // Decode is back-pressuring: hold PC and slot.
                        pc_d = pc_q;
                    end
                end
                HALTED: begin
                    pc_d = pc_q;
                end
                FAULT: begin
                    pc_d = pc_q;
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // Program counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Output slot towards decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_insn_q  <= 32'h0000_0000;
            out_pc_q    <= 32'h0000_0000;
        end else begin
            out_valid_q <= out_valid_d;
            out_insn_q  <= out_insn_d;
            out_pc_q    <= out_pc_d;
        end
    end

    // Registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign imem_addr = pc_q;
    assign out_valid = out_valid_q;
    assign out_insn  = out_insn_q;
    assign out_pc    = out_pc_q;
    assign halted    = halted_q;
    assign fault     = fault_q;

endmodule : instruction_fetch_unit

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Program-counter and fetch stage directly upstream of the 32-word Harvard instruction ROM. It drives the ROM word address, captures the combinational read data into a registered instruction/PC pair, and hands them to decode over a valid/ready handshake. It also handles branch/jump redirects, halt-sentinel detection and out-of-range PC faults.

## Interface
Parameters:
- DEPTH, 32: number of instruction words in the ROM; valid PCs are 0..DEPTH-1.
- RESET_PC, 32'h0: PC loaded on reset.
- HALT_INSN, 32'hFFFFFFFF: halt sentinel word; it is never forwarded to decode.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- imem_addr  out  32  ROM word index; equals the PC register (word-addressed, not byte).
- imem_rdata  in  32  ROM combinational read data for imem_addr, same cycle.
- redirect_valid  in  1  load a new PC (branch/jump taken).
- redirect_target  in  32  new PC (word index), sampled when redirect_valid=1.
- out_valid  out  1  out_insn/out_pc hold a valid instruction.
- out_ready  in  1  decode accepts; transfer occurs when out_valid && out_ready.
- out_insn  out  32  fetched instruction.
- out_pc  out  32  word address of out_insn.
- halted  out  1  HALTED state indicator.
- fault  out  1  FAULT state indicator (PC out of range).

## Operation
- States: FETCH, HALTED, FAULT. Reset enters FETCH.
- Reset values: pc=RESET_PC, out_valid=0, out_insn=0, out_pc=0, halted=0, fault=0.
- Output slot free means out_valid=0 or (out_valid && out_ready).
- FETCH, no redirect:
  - pc >= DEPTH: go to FAULT, fault<=1, no capture. Any valid output still pending is held until accepted.
  - Slot free and imem_rdata == HALT_INSN: go to HALTED, halted<=1. The PC is not incremented. The sentinel is not captured, and out_valid<=0 if the slot was consumed.
  - Slot free, otherwise: out_insn<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+1 (32-bit wrap; wrap is irrelevant because the DEPTH check fires first).
  - Slot not free: stall. pc and all outputs hold.
- Redirect (any state) has priority over everything above:
  - pc<=redirect_target, out_valid<=0, state<=FETCH, halted<=0, fault<=0.
  - If out_valid && out_ready in the same cycle, that transfer still counts as completed (decode owns it). Otherwise the held instruction is discarded.
- HALTED/FAULT without redirect: no fetch, pc holds. A pending valid output is drained normally (out_valid clears once accepted).
- rst_n assertion mid-operation clears everything asynchronously, regardless of handshake state.

## Timing
- Fetch latency: an instruction is captured on the edge ending the cycle in which its PC is on imem_addr. out_valid rises 1 cycle after the PC is presented.
- First instruction after reset release: out_valid=1 after the first rising edge with rst_n=1.
- Throughput: 1 instruction/cycle while out_ready=1.
- Redirect in cycle N: imem_addr=target in cycle N+1, and the target instruction is valid in cycle N+2. There is no bubble beyond this.
- halted/fault assert 1 cycle after the detecting cycle and are registered, with no combinational paths to outputs. The only combinational path is imem_addr→imem_rdata through the ROM.
- out_insn/out_pc are stable while out_valid && !out_ready.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (FETCH, HALTED, FAULT);
  - the constant HALT_INSN = 32'hFFFFFFFF;
  - the constant IMEM_DEPTH = 32;
  - the word-width constant.
- Flat module. The PC register, output register and FSM are small enough that no sub-module is warranted.

## Test plan
- ROM {0:8C220000, 1:FFFFFFFF}, out_ready=1, release reset:
  - cycle 1: out_valid=1, out_insn=8C220000, out_pc=0;
  - cycle 2: out_valid=0, halted=1;
  - imem_addr stays 1.
- ROM words 0..3 distinct, out_ready low for cycles 2–4: out_insn/out_pc hold word 0 and imem_addr holds 1. Once ready, words 1..3 follow on consecutive cycles.
- Redirect to 5 while out_valid=1 and out_ready=0: out_valid=0 next cycle, then out_pc=5 with ROM[5] one cycle later. The discarded word is never transferred.
- Sequential run through word 31 with no halt: word 31 is delivered, then fault=1 with imem_addr=32 and out_valid low after the drain. Redirect to 0 clears fault and resumes at word 0.
- Redirect and halt-detection in the same cycle: redirect wins, halted stays 0, and the fetch continues from the target.
- Assert rst_n=0 mid-stream with out_valid=1: all outputs go to reset values immediately, without waiting for an edge. After release, the fetch restarts at RESET_PC.
